// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_stage
// Brief   : ID/EX stage: decodes ALU control, registers operands, forwards.
// Rev     : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
  parameter int          XLEN    = 32,
  parameter logic [3:0]  NOP_CTL = 4'b0011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            ex_stall,
  input  logic            ex_flush,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [3:0]      ALU_ctl,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_is_branch,
  output logic            ex_br_on_zero,
  output logic            ex_illegal
);

  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_LD  = 7'b0000011;
  localparam logic [6:0] c_OP_ST  = 7'b0100011;
  localparam logic [6:0] c_OP_BR  = 7'b1100011;
  localparam logic [6:0] c_OP_LUI = 7'b0110111;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_ok;
  logic [3:0] w_code;
  logic       w_br;
  logic       w_boz;
  logic       w_bimm;
  logic       w_azero;
  logic       w_unused_instr;

  assign w_opcode       = id_instr[6:0];
  assign w_f3           = id_instr[14:12];
  assign w_f7b5         = id_instr[30];
  assign w_unused_instr = ^{id_instr[31], id_instr[29:15]};

  always_comb begin
    w_ok    = 1'b0;
    w_code  = NOP_CTL;
    w_br    = 1'b0;
    w_boz   = 1'b0;
    w_bimm  = 1'b0;
    w_azero = 1'b0;
    case (w_opcode)
      c_OP_R, c_OP_I: begin
        w_bimm = (w_opcode == c_OP_I);
        case (w_f3)
          3'b000: begin
            w_ok   = 1'b1;
            w_code = (w_opcode == c_OP_R && w_f7b5) ? 4'b0110 : 4'b0010;
          end
          3'b111: begin w_ok = 1'b1; w_code = 4'b0000; end
          3'b110: begin w_ok = 1'b1; w_code = 4'b0001; end
          3'b001: begin w_ok = 1'b1; w_code = 4'b1001; end
          3'b101: begin w_ok = !w_f7b5; w_code = 4'b1010; end
          default: w_ok = 1'b0;
        endcase
      end
      c_OP_LD, c_OP_ST: begin
        w_ok = 1'b1; w_code = 4'b0010; w_bimm = 1'b1;
      end
      c_OP_BR: begin
        w_br = 1'b1;
        case (w_f3)
          3'b000: begin w_ok = 1'b1; w_code = 4'b0110; w_boz = 1'b1; end
          3'b001: begin w_ok = 1'b1; w_code = 4'b1111; end
          3'b100: begin w_ok = 1'b1; w_code = 4'b0111; end
          3'b101: begin w_ok = 1'b1; w_code = 4'b1000; end
          default: w_ok = 1'b0;
        endcase
      end
      c_OP_LUI: begin
        w_ok = 1'b1; w_code = 4'b0010; w_bimm = 1'b1; w_azero = 1'b1;
      end
      default: w_ok = 1'b0;
    endcase
  end

  logic            r_valid;
  logic [3:0]      r_ctl;
  logic [4:0]      r_rd;
  logic            r_br;
  logic            r_boz;
  logic            r_ill;
  logic            r_bimm;
  logic            r_azero;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;

  always_ff @(posedge clk) begin
    if (reset || ex_flush || (!ex_stall && !id_valid)) begin
      r_valid <= 1'b0;
      r_ctl   <= NOP_CTL;
      r_rd    <= 5'd0;
      r_br    <= 1'b0;
      r_boz   <= 1'b0;
      r_ill   <= 1'b0;
      r_bimm  <= 1'b0;
      r_azero <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
    end else if (!ex_stall) begin
      r_valid <= 1'b1;
      // Illegal ops carry no branch/operand-mode meaning, only the flag.
      r_ctl   <= w_ok ? w_code : NOP_CTL;
      r_rd    <= id_instr[11:7];
      r_br    <= w_ok & w_br;
      r_boz   <= w_ok & w_boz;
      r_ill   <= !w_ok;
      r_bimm  <= w_ok & w_bimm;
      r_azero <= w_ok & w_azero;
      r_rs1   <= id_rs1_data;
      r_rs2   <= id_rs2_data;
      r_imm   <= id_imm;
    end
  end

  logic [XLEN-1:0] w_fa;
  logic [XLEN-1:0] w_fb;

  // Forwarding sits after the register so a stalled op sees fresh results.
  always_comb begin
    w_fa = r_rs1;
    w_fb = r_rs2;
    case (fwd_a_sel)
      2'b01:   w_fa = exmem_result;
      2'b10:   w_fa = memwb_result;
      default: w_fa = r_rs1;
    endcase
    case (fwd_b_sel)
      2'b01:   w_fb = exmem_result;
      2'b10:   w_fb = memwb_result;
      default: w_fb = r_rs2;
    endcase
  end

  assign ex_valid      = r_valid;
  assign ALU_ctl       = r_ctl;
  assign ex_rd         = r_rd;
  assign ex_is_branch  = r_br;
  assign ex_br_on_zero = r_boz;
  assign ex_illegal    = r_ill;
  assign in1           = (r_valid && !r_azero) ? w_fa : '0;
  assign in2           = !r_valid ? '0 : (r_bimm ? r_imm : w_fb);
  assign ex_store_data = r_valid ? w_fb : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_stage
// Brief   : Directed bench with an instruction-table reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;
  localparam int         XLEN = 32;
  localparam logic [3:0] NOP  = 4'b0011;

  logic            clk = 1'b0;
  logic            reset, id_valid, ex_stall, ex_flush;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            ex_valid, ex_is_branch, ex_br_on_zero, ex_illegal;
  logic [3:0]      ALU_ctl;
  logic [XLEN-1:0] in1, in2, ex_store_data;
  logic [4:0]      ex_rd;

  alu_issue_stage #(.XLEN(XLEN), .NOP_CTL(NOP)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ALU_ctl(ALU_ctl), .in1(in1), .in2(in2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_is_branch(ex_is_branch),
    .ex_br_on_zero(ex_br_on_zero), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // One row per supported instruction; anything not found is illegal.
  typedef struct {
    logic [6:0] op; logic [2:0] f3; bit any_f3; bit chk_f7; bit f7;
    logic [3:0] ctl; bit br; bit boz; bit bimm; bit azero;
  } op_t;

  typedef struct {
    bit valid; logic [3:0] ctl; logic [4:0] rd; bit br; bit boz; bit ill;
    bit bimm; bit azero; logic [XLEN-1:0] rs1; logic [XLEN-1:0] rs2; logic [XLEN-1:0] imm;
  } st_t;

  op_t tbl[$];
  st_t m;
  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_en = 1'b0;

  function automatic st_t bubble();
    st_t s;
    s.valid = 0; s.ctl = NOP; s.rd = 0; s.br = 0; s.boz = 0; s.ill = 0;
    s.bimm = 0; s.azero = 0; s.rs1 = 0; s.rs2 = 0; s.imm = 0;
    return s;
  endfunction

  function automatic st_t decode(logic [31:0] ins, logic [XLEN-1:0] a, b, im);
    st_t s;
    bit  found = 0;
    s = bubble();
    s.valid = 1; s.rd = ins[11:7]; s.rs1 = a; s.rs2 = b; s.imm = im; s.ill = 1;
    foreach (tbl[i]) begin
      if (!found && tbl[i].op == ins[6:0] && (tbl[i].any_f3 || tbl[i].f3 == ins[14:12])
          && (!tbl[i].chk_f7 || tbl[i].f7 == ins[30])) begin
        found = 1; s.ill = 0; s.ctl = tbl[i].ctl; s.br = tbl[i].br; s.boz = tbl[i].boz;
        s.bimm = tbl[i].bimm; s.azero = tbl[i].azero;
      end
    end
    return s;
  endfunction

  function automatic logic [XLEN-1:0] fwd(logic [1:0] sel, logic [XLEN-1:0] r);
    return (sel == 2'b01) ? exmem_result : (sel == 2'b10) ? memwb_result : r;
  endfunction

  always @(posedge clk) begin
    if (reset || ex_flush) m <= bubble();
    else if (!ex_stall)   m <= id_valid ? decode(id_instr, id_rs1_data, id_rs2_data, id_imm) : bubble();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [XLEN-1:0] e1, e2, es;
      bit bad;
      es = m.valid ? fwd(fwd_b_sel, m.rs2) : '0;
      e1 = (m.valid && !m.azero) ? fwd(fwd_a_sel, m.rs1) : '0;
      e2 = !m.valid ? '0 : (m.bimm ? m.imm : fwd(fwd_b_sel, m.rs2));
      bad = (ex_valid !== m.valid) || (ALU_ctl !== m.ctl) || (ex_rd !== m.rd) ||
            (ex_is_branch !== m.br) || (ex_br_on_zero !== m.boz) || (ex_illegal !== m.ill) ||
            (ex_store_data !== es) || (!m.ill && ((in1 !== e1) || (in2 !== e2)));
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL model t=%0t got v=%b ctl=%b rd=%0d br=%b boz=%b ill=%b in1=%h in2=%h sd=%h required v=%b ctl=%b rd=%0d br=%b boz=%b ill=%b in1=%h in2=%h sd=%h",
                 $time, ex_valid, ALU_ctl, ex_rd, ex_is_branch, ex_br_on_zero, ex_illegal, in1, in2, ex_store_data,
                 m.valid, m.ctl, m.rd, m.br, m.boz, m.ill, e1, e2, es);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [XLEN-1:0] a, b, im);
    id_valid = 1; id_instr = ins; id_rs1_data = a; id_rs2_data = b; id_imm = im;
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_SUB = 32'h402081B3;
  localparam logic [31:0] I_BNE  = 32'h00209063, I_BEQ = 32'h00208063;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3, I_LUI = 32'h123452B7;
  logic [31:0] sweep [14] = '{32'h00008213, 32'h0000A303, 32'h0020A223, 32'h0000D213,
                              32'h0000F213, 32'h0020E1B3, 32'h002091B3, 32'h0020C063,
                              32'h0020D063, 32'h0020C1B3, 32'h4000D213, 32'h0000006F,
                              32'h0020F1B3, 32'h0020D1B3};

  initial begin
    tbl.push_back('{7'h33, 3'b000, 0, 1, 0, 4'b0010, 0, 0, 0, 0});
    tbl.push_back('{7'h33, 3'b000, 0, 1, 1, 4'b0110, 0, 0, 0, 0});
    tbl.push_back('{7'h33, 3'b111, 0, 0, 0, 4'b0000, 0, 0, 0, 0});
    tbl.push_back('{7'h33, 3'b110, 0, 0, 0, 4'b0001, 0, 0, 0, 0});
    tbl.push_back('{7'h33, 3'b001, 0, 0, 0, 4'b1001, 0, 0, 0, 0});
    tbl.push_back('{7'h33, 3'b101, 0, 1, 0, 4'b1010, 0, 0, 0, 0});
    tbl.push_back('{7'h13, 3'b000, 0, 0, 0, 4'b0010, 0, 0, 1, 0});
    tbl.push_back('{7'h13, 3'b111, 0, 0, 0, 4'b0000, 0, 0, 1, 0});
    tbl.push_back('{7'h13, 3'b110, 0, 0, 0, 4'b0001, 0, 0, 1, 0});
    tbl.push_back('{7'h13, 3'b001, 0, 0, 0, 4'b1001, 0, 0, 1, 0});
    tbl.push_back('{7'h13, 3'b101, 0, 1, 0, 4'b1010, 0, 0, 1, 0});
    tbl.push_back('{7'h03, 3'b000, 1, 0, 0, 4'b0010, 0, 0, 1, 0});
    tbl.push_back('{7'h23, 3'b000, 1, 0, 0, 4'b0010, 0, 0, 1, 0});
    tbl.push_back('{7'h63, 3'b000, 0, 0, 0, 4'b0110, 1, 1, 0, 0});
    tbl.push_back('{7'h63, 3'b001, 0, 0, 0, 4'b1111, 1, 0, 0, 0});
    tbl.push_back('{7'h63, 3'b100, 0, 0, 0, 4'b0111, 1, 0, 0, 0});
    tbl.push_back('{7'h63, 3'b101, 0, 0, 0, 4'b1000, 1, 0, 0, 0});
    tbl.push_back('{7'h37, 3'b000, 1, 0, 0, 4'b0010, 0, 0, 1, 1});

    reset = 1; id_valid = 0; id_instr = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    ex_stall = 0; ex_flush = 0; fwd_a_sel = 0; fwd_b_sel = 0; exmem_result = 0; memwb_result = 0;
    tick();
    chk_en = 1;
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_ctl", 32'(ALU_ctl), 32'(NOP));
    chk("reset_in1", in1, 0);
    reset = 0;

    issue(I_ADD, 5, 7, 0);
    tick();
    chk("add_ctl", 32'(ALU_ctl), 32'b0010); chk("add_in1", in1, 5);
    chk("add_in2", in2, 7); chk("add_rd", 32'(ex_rd), 3); chk("add_valid", 32'(ex_valid), 1);

    issue(I_SUB, 9, 4, 0); fwd_a_sel = 2'b01; exmem_result = 20;
    tick();
    chk("sub_in1", in1, 20); chk("sub_in2", in2, 4); chk("sub_ctl", 32'(ALU_ctl), 32'b0110);
    fwd_a_sel = 0;

    issue(I_BNE, 1, 1, 0);
    tick();
    ex_stall = 1; issue(I_ADD, 11, 22, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin fwd_b_sel = 2'b10; memwb_result = 32'h55; end
      tick();
      chk("stall_ctl", 32'(ALU_ctl), 32'b1111);
      chk("stall_br", 32'({ex_is_branch, ex_br_on_zero}), 32'b10);
    end
    chk("stall_fwd_in2", in2, 32'h55);
    ex_stall = 0; fwd_b_sel = 0;
    tick();
    chk("post_stall_ctl", 32'(ALU_ctl), 32'b0010); chk("post_stall_in1", in1, 11);

    ex_stall = 1; ex_flush = 1; fwd_a_sel = 2'b01; exmem_result = 32'hABCD;
    tick();
    chk("flush_valid", 32'(ex_valid), 0); chk("flush_ctl", 32'(ALU_ctl), 32'b0011);
    chk("flush_in1", in1, 0); chk("flush_in2", in2, 0);
    ex_stall = 0; ex_flush = 0; fwd_a_sel = 0;

    issue(I_SRA, 3, 4, 0);
    tick();
    chk("sra_ctl", 32'(ALU_ctl), 32'b0011); chk("sra_ill", 32'(ex_illegal), 1);
    issue(I_LUI, 32'hDEAD, 32'hBEEF, 32'h12345000);
    tick();
    chk("lui_in1", in1, 0); chk("lui_in2", in2, 32'h12345000); chk("lui_ctl", 32'(ALU_ctl), 32'b0010);

    id_valid = 0;
    tick();
    chk("idle_valid", 32'(ex_valid), 0); chk("idle_ctl", 32'(ALU_ctl), 32'b0011);

    issue(I_BEQ, 6, 6, 0);
    tick();
    chk("beq_ctl", 32'(ALU_ctl), 32'b0110); chk("beq_boz", 32'(ex_br_on_zero), 1);
    reset = 1; ex_stall = 1; issue(I_ADD, 1, 2, 0);
    tick();
    reset = 0; ex_stall = 0; id_valid = 0;
    chk("rst_valid", 32'(ex_valid), 0); chk("rst_ctl", 32'(ALU_ctl), 32'b0011);
    chk("rst_flags", 32'({ex_is_branch, ex_br_on_zero, ex_illegal, ex_rd}), 0);
    chk("rst_ops", in1 | in2 | ex_store_data, 0);

    for (int i = 0; i < 14; i++) begin
      issue(sweep[i], 32'(i * 3 + 1), 32'(i * 7 + 2), 32'(32'hFFFF_FF00 + i));
      id_valid     = (i % 5 != 4);
      fwd_a_sel    = 2'(i % 4);
      fwd_b_sel    = 2'((i + 1) % 4);
      exmem_result = 32'h1000 + i;
      memwb_result = 32'h2000 + i;
      tick();
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
